hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Stall controller for the five-stage pipeline: decodes the instructions in D, E and M, computes Tuse/Tnew hazards and multiply/divide-unit occupancy, and drives the freeze and bubble controls of the F/D and D/E pipeline registers. It is the producer side of the D/E register's `halt` input. It contains a registered MDU busy counter, so its stall decisions depend on history, not just on the current instruction words.

## Interface
Parameters:
- `MULT_CYC`, default 5: busy cycles after mult/multu leaves E.
- `DIV_CYC`, default 10: busy cycles after div/divu leaves E.

Ports:
- `clk`  in  1: clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-low reset.
- `d_instr`  in  32: instruction in D.
- `e_instr`  in  32: instruction in E.
- `m_instr`  in  32: instruction in M.
- `pc_en`  out  1: PC write enable; 0 while stalling.
- `fd_en`  out  1: F/D register load enable; 0 while stalling.
- `de_halt`  out  1: D/E register loads a bubble (all-zero instr) this edge.
- `mdu_busy`  out  1: MDU counter nonzero.
- `stall_cnt`  out  32: stall-cycle count; present only with HAZARD_STAT_EN.

## Operation
- Recognised opcodes: add, sub, ori, lui, lw, sw, beq, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Anything else, including 0x00000000, is a nop: no use and no write.
- Tuse in D:
  - beq rs/rt = 0; jr rs = 0.
  - add/sub rs,rt = 1; ori rs = 1.
  - lw rs = 1; sw rs = 1, rt = 2.
  - mult/div/mthi/mtlo rs (and rt for mult/div) = 1.
- Tnew and destination, E stage:
  - lw = 2, dest rt.
  - add/sub, mfhi/mflo = 1, dest rd.
  - ori/lui = 1, dest rt.
  - jal = 0, dest 31.
- Tnew and destination, M stage: lw = 1, all others 0.
- Hazard stall: D source register equals an E or M destination, the register is nonzero, and Tuse < Tnew.
- MDU stall: D holds an md-class instruction (mult* / div* / mf* / mt*) and either `mdu_busy` = 1 or E holds mult* / div*.
- stall = hazard stall OR MDU stall. While stalled:
  - `pc_en` = 0, `fd_en` = 0, `de_halt` = 1.
  - Otherwise `pc_en` = `fd_en` = 1 and `de_halt` = 0.
- MDU counter:
  - Loads `MULT_CYC` when E holds mult/multu, and `DIV_CYC` when E holds div/divu.
  - Otherwise decrements while nonzero, saturating at 0.
  - A load overrides a decrement.
- Counter width is `$clog2(DIV_CYC+1)`; `MULT_CYC` must not exceed `DIV_CYC`.

## Timing
- Reset (`reset` = 0 at posedge): counter = 0, `stall_cnt` = 0. Outputs settle to `mdu_busy` = 0 and, with zero instruction inputs, `pc_en` = `fd_en` = 1, `de_halt` = 0.
- `pc_en`, `fd_en`, `de_halt` are combinational from the instruction inputs and the counter, valid within the same cycle with no registered latency.
- `mdu_busy` is registered: it rises the cycle after mult/div is in E and stays high for exactly `MULT_CYC` / `DIV_CYC` cycles.
- A new mult/div reaching E while busy reloads the counter. This cannot occur in practice because of the MDU stall, but the reload behaviour is required.
- Reset asserted mid-count clears the counter on that edge. Reset wins over load.
- Simultaneous hazard and MDU stall produces a single stall cycle per cycle; causes are not counted twice.

## Configuration
- `HAZARD_STAT_EN` defined: the `stall_cnt` port exists.
  - 32-bit counter, +1 on every posedge where stall = 1 and `reset` = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - opcode/funct constants;
  - Tuse/Tnew encoding (2-bit);
  - `NOP_INSTR` = 32'h0.
- Sub-module `instr_class`: combinational decode of one instruction word into rs, rt, dest, Tuse_rs, Tuse_rt, Tnew_E, md-class and start-type flags. It is instantiated three times (D, E, M).
- Top level holds only the comparators, the MDU counter and the statistics counter.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with random instructions, then release with all-zero instructions -> `pc_en` = 1, `de_halt` = 0, `mdu_busy` = 0.
- Load-use: E = `lw $8,0($0)`, D = `add $9,$8,$8` -> `de_halt` = 1, `pc_en` = 0. Next cycle M = lw, E = bubble -> no stall.
- Branch: M = `lw $4`, D = `beq $4,$0` -> stall. With E = `ori $0,...` and D = `beq $0,$0` -> no stall.
- MDU: E = mult for one cycle, then D = `mflo $2` -> stall with `mdu_busy` = 1 for exactly 5 cycles. Same sequence with div -> exactly 10 cycles.
- Reset mid-count: assert `reset` = 0 at busy cycle 3 of a div -> `mdu_busy` = 0 on the next cycle.
- With `HAZARD_STAT_EN`: the load-use case followed by the div case -> `stall_cnt` = 12 (1 load-use cycle, 1 cycle with div in E, 10 busy cycles).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage pipeline control logic.
// Holds opcode/funct constants, the 2-bit Tuse/Tnew encodings, the
// multiply/divide start-type enum and the canonical nop word.
package cpu_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;

  // Tuse: cycles until D needs the operand. TuseNone (3) is never below any
  // Tnew, so an unused source can never cause a stall.
  typedef logic [1:0] tuse_t;
  localparam tuse_t Tuse0    = 2'd0;
  localparam tuse_t Tuse1    = 2'd1;
  localparam tuse_t Tuse2    = 2'd2;
  localparam tuse_t TuseNone = 2'd3;

  // Tnew: cycles until a stage's result is available for forwarding.
  typedef logic [1:0] tnew_t;
  localparam tnew_t Tnew0 = 2'd0;
  localparam tnew_t Tnew1 = 2'd1;
  localparam tnew_t Tnew2 = 2'd2;

  typedef enum logic [1:0] {
    StartNone,
    StartMult,
    StartDiv
  } start_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Tnew one stage further down the pipe, saturating at zero.
  function automatic tnew_t tnew_next(input tnew_t t);
    return (t == Tnew0) ? Tnew0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational instruction classifier.
// Ports:
//   instr    in  32  instruction word
//   rs, rt   out 5   raw source register fields
//   dest     out 5   destination register (0 when the instruction writes nothing)
//   tuse_rs  out 2   Tuse of rs in D (TuseNone if unused)
//   tuse_rt  out 2   Tuse of rt in D (TuseNone if unused)
//   tnew     out 2   Tnew when the instruction sits in E
//   md_class out 1   mult/div/mfhi/mflo/mthi/mtlo
//   start    out 2   MDU start type (mult* / div*)
// Unrecognised words, including NOP_INSTR, decode as no use and no write.
module instr_class
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output tuse_t       tuse_rs,
  output tuse_t       tuse_rt,
  output tnew_t       tnew,
  output logic        md_class,
  output start_e      start
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rd = instr[15:11];
  assign rs = instr[25:21];
  assign rt = instr[20:16];

  always_comb begin
    dest     = 5'd0;
    tuse_rs  = TuseNone;
    tuse_rt  = TuseNone;
    tnew     = Tnew0;
    md_class = 1'b0;
    start    = StartNone;
    case (op)
      OpRtype: begin
        case (fn)
          FnAdd, FnSub: begin
            tuse_rs = Tuse1;
            tuse_rt = Tuse1;
            dest    = rd;
            tnew    = Tnew1;
          end
          FnJr: tuse_rs = Tuse0;
          FnMult, FnMultu: begin
            tuse_rs  = Tuse1;
            tuse_rt  = Tuse1;
            md_class = 1'b1;
            start    = StartMult;
          end
          FnDiv, FnDivu: begin
            tuse_rs  = Tuse1;
            tuse_rt  = Tuse1;
            md_class = 1'b1;
            start    = StartDiv;
          end
          FnMthi, FnMtlo: begin
            tuse_rs  = Tuse1;
            md_class = 1'b1;
          end
          FnMfhi, FnMflo: begin
            dest     = rd;
            tnew     = Tnew1;
            md_class = 1'b1;
          end
          default: ;
        endcase
      end
      OpJal: begin
        dest = 5'd31;
        tnew = Tnew0;
      end
      OpBeq: begin
        tuse_rs = Tuse0;
        tuse_rt = Tuse0;
      end
      OpOri: begin
        tuse_rs = Tuse1;
        dest    = rt;
        tnew    = Tnew1;
      end
      OpLui: begin
        dest = rt;
        tnew = Tnew1;
      end
      OpLw: begin
        tuse_rs = Tuse1;
        dest    = rt;
        tnew    = Tnew2;
      end
      OpSw: begin
        tuse_rs = Tuse1;
        tuse_rt = Tuse2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall controller.
// Decodes D/E/M, detects Tuse/Tnew data hazards and MDU occupancy, and drives
// the F/D freeze and D/E bubble controls.
// Ports:
//   clk        in  1   clock
//   reset      in  1   synchronous active-low reset
//   d_instr    in  32  instruction in D
//   e_instr    in  32  instruction in E
//   m_instr    in  32  instruction in M
//   pc_en      out 1   PC write enable (0 while stalling)
//   fd_en      out 1   F/D load enable (0 while stalling)
//   de_halt    out 1   D/E loads a bubble this edge
//   mdu_busy   out 1   MDU busy counter nonzero
//   stall_cnt  out 32  stall-cycle count (only with HAZARD_STAT_EN)
// Configuration macro: HAZARD_STAT_EN adds the stall statistics counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_instr,
  input  logic [31:0] e_instr,
  input  logic [31:0] m_instr,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_halt,
  output logic        mdu_busy
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(DIV_CYC + 1);

  logic [4:0] d_rs, d_rt, d_dest, e_rs, e_rt, e_dest, m_rs, m_rt, m_dest;
  tuse_t      d_tuse_rs, d_tuse_rt, e_tuse_rs, e_tuse_rt, m_tuse_rs, m_tuse_rt;
  tnew_t      d_tnew, e_tnew, m_tnew_e, m_tnew;
  logic       d_md, e_md, m_md;
  start_e     d_start, e_start, m_start;

  instr_class u_dec_d (
    .instr    (d_instr),
    .rs       (d_rs),
    .rt       (d_rt),
    .dest     (d_dest),
    .tuse_rs  (d_tuse_rs),
    .tuse_rt  (d_tuse_rt),
    .tnew     (d_tnew),
    .md_class (d_md),
    .start    (d_start)
  );

  instr_class u_dec_e (
    .instr    (e_instr),
    .rs       (e_rs),
    .rt       (e_rt),
    .dest     (e_dest),
    .tuse_rs  (e_tuse_rs),
    .tuse_rt  (e_tuse_rt),
    .tnew     (e_tnew),
    .md_class (e_md),
    .start    (e_start)
  );

  instr_class u_dec_m (
    .instr    (m_instr),
    .rs       (m_rs),
    .rt       (m_rt),
    .dest     (m_dest),
    .tuse_rs  (m_tuse_rs),
    .tuse_rt  (m_tuse_rt),
    .tnew     (m_tnew_e),
    .md_class (m_md),
    .start    (m_start)
  );

  // Decoder outputs that this stage does not need.
  logic unused_dec;
  assign unused_dec = ^{d_dest, d_tnew, d_start, e_rs, e_rt, e_tuse_rs, e_tuse_rt, e_md,
                        m_rs, m_rt, m_tuse_rs, m_tuse_rt, m_md, m_start};

  // In M every result is one cycle closer than it was in E (only lw stays nonzero).
  assign m_tnew = tnew_next(m_tnew_e);

  function automatic logic src_hazard(input logic [4:0] src, input tuse_t tuse,
                                      input logic [4:0] ed, input tnew_t et,
                                      input logic [4:0] md, input tnew_t mt);
    return (src != 5'd0) && (((src == ed) && (tuse < et)) || ((src == md) && (tuse < mt)));
  endfunction

  logic [CntW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic            hz_stall, mdu_stall, stall;

  always_comb begin
    hz_stall  = src_hazard(d_rs, d_tuse_rs, e_dest, e_tnew, m_dest, m_tnew) |
                src_hazard(d_rt, d_tuse_rt, e_dest, e_tnew, m_dest, m_tnew);
    mdu_stall = d_md && (mdu_busy || (e_start != StartNone));
    stall     = hz_stall | mdu_stall;
    pc_en     = ~stall;
    fd_en     = ~stall;
    de_halt   = stall;
  end

  // A load from E always wins over the decrement.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    unique case (e_start)
      StartMult: mdu_cnt_d = CntW'(MULT_CYC);
      StartDiv:  mdu_cnt_d = CntW'(DIV_CYC);
      default: begin
        if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - CntW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdu_cnt_q <= '0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign mdu_busy = (mdu_cnt_q != '0);

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MultCyc = 5;
  localparam int DivCyc  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] d_instr = 32'h0;
  logic [31:0] e_instr = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        pc_en, fd_en, de_halt, mdu_busy;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MULT_CYC (MultCyc),
    .DIV_CYC  (DivCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d_instr  (d_instr),
    .e_instr  (e_instr),
    .m_instr  (m_instr),
    .pc_en    (pc_en),
    .fd_en    (fd_en),
    .de_halt  (de_halt),
    .mdu_busy (mdu_busy)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                         input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // ---------------- reference model ----------------
  // Source operands of a D instruction: register number (-1 if none) and Tuse.
  function automatic void src_regs(input logic [31:0] i, output int ra, output int ua,
                                   output int rb, output int ub);
    int op, fn, rs, rt;
    op = int'(i[31:26]); fn = int'(i[5:0]); rs = int'(i[25:21]); rt = int'(i[20:16]);
    ra = -1; rb = -1; ua = 9; ub = 9;
    if (op == 0) begin
      if (fn == 'h20 || fn == 'h22 || (fn >= 'h18 && fn <= 'h1b)) begin
        ra = rs; ua = 1; rb = rt; ub = 1;
      end else if (fn == 'h08) begin
        ra = rs; ua = 0;
      end else if (fn == 'h11 || fn == 'h13) begin
        ra = rs; ua = 1;
      end
    end else if (op == 'h04) begin
      ra = rs; ua = 0; rb = rt; ub = 0;
    end else if (op == 'h0d || op == 'h23) begin
      ra = rs; ua = 1;
    end else if (op == 'h2b) begin
      ra = rs; ua = 1; rb = rt; ub = 2;
    end
  endfunction

  // Destination (0 = none) and Tnew while in E.
  function automatic void dst_of(input logic [31:0] i, output int dst, output int tn);
    int op, fn;
    op = int'(i[31:26]); fn = int'(i[5:0]);
    dst = 0; tn = 0;
    if (op == 'h23) begin dst = int'(i[20:16]); tn = 2; end
    else if (op == 'h0d || op == 'h0f) begin dst = int'(i[20:16]); tn = 1; end
    else if (op == 'h03) begin dst = 31; tn = 0; end
    else if (op == 0 && (fn == 'h20 || fn == 'h22 || fn == 'h10 || fn == 'h12)) begin
      dst = int'(i[15:11]); tn = 1;
    end
  endfunction

  function automatic bit is_md(input logic [31:0] i);
    int fn;
    fn = int'(i[5:0]);
    return (i[31:26] == 6'h00) && (fn >= 'h10 && fn <= 'h13 || fn >= 'h18 && fn <= 'h1b);
  endfunction

  // Busy cycles an instruction in E starts (0 if none).
  function automatic int start_cyc(input logic [31:0] i);
    if (i[31:26] != 6'h00) return 0;
    if (i[5:0] == 6'h18 || i[5:0] == 6'h19) return MultCyc;
    if (i[5:0] == 6'h1a || i[5:0] == 6'h1b) return DivCyc;
    return 0;
  endfunction

  function automatic bit reg_hz(input int r, input int u, input int de, input int te,
                                input int dm, input int tm);
    if (r <= 0) return 0;
    return (r == de && u < te) || (r == dm && u < tm);
  endfunction

  function automatic bit ref_stall(input logic [31:0] d, input logic [31:0] e,
                                   input logic [31:0] m, input int cnt);
    int ra, ua, rb, ub, de, te, dm, tm, tmp;
    src_regs(d, ra, ua, rb, ub);
    dst_of(e, de, te);
    dst_of(m, dm, tmp);
    tm = (m[31:26] == 6'h23) ? 1 : 0;
    return reg_hz(ra, ua, de, te, dm, tm) || reg_hz(rb, ub, de, te, dm, tm) ||
           (is_md(d) && (cnt > 0 || start_cyc(e) > 0));
  endfunction

  int          model_cnt = 0;
  logic [31:0] model_stat = 32'h0;

  always @(posedge clk) begin
    if (!reset) begin
      model_cnt  <= 0;
      model_stat <= 32'h0;
    end else begin
      if (ref_stall(d_instr, e_instr, m_instr, model_cnt)) model_stat <= model_stat + 32'd1;
      if (start_cyc(e_instr) > 0) model_cnt <= start_cyc(e_instr);
      else if (model_cnt > 0) model_cnt <= model_cnt - 1;
    end
  end

  function automatic logic [31:0] rand_instr();
    int a, b, c;
    a = $urandom_range(0, 4); if (a == 4) a = 31;
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    case ($urandom_range(0, 19))
      0:  return r_type(a, b, c, 6'h20);
      1:  return r_type(a, b, c, 6'h22);
      2:  return i_type(6'h0d, a, b, $urandom_range(0, 65535));
      3:  return i_type(6'h0f, 0, b, $urandom_range(0, 65535));
      4:  return i_type(6'h23, a, b, $urandom_range(0, 255));
      5:  return i_type(6'h2b, a, b, $urandom_range(0, 255));
      6:  return i_type(6'h04, a, b, $urandom_range(0, 255));
      7:  return {6'h03, 26'($urandom)};
      8:  return r_type(a, 0, 0, 6'h08);
      9:  return r_type(a, b, 0, 6'h18);
      10: return r_type(a, b, 0, 6'h19);
      11: return r_type(a, b, 0, 6'h1a);
      12: return r_type(a, b, 0, 6'h1b);
      13: return r_type(0, 0, c, 6'h10);
      14: return r_type(0, 0, c, 6'h12);
      15: return r_type(a, 0, 0, 6'h11);
      16: return r_type(a, 0, 0, 6'h13);
      17: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Apply inputs mid-cycle and let the combinational outputs settle.
  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic rst);
    @(negedge clk);
    d_instr = d; e_instr = e; m_instr = m; reset = rst;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(rand_instr(), rand_instr(), rand_instr(), 1'b0);
    drive(rand_instr(), rand_instr(), rand_instr(), 1'b0);
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en: got %b want 1", pc_en); end
    checks++;
    if (de_halt !== 1'b0) begin errors++; $display("FAIL reset_de_halt: got %b want 0", de_halt); end
    checks++;
    if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
`ifdef HAZARD_STAT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [31:0] lw8, add9;
    lw8  = i_type(6'h23, 0, 8, 0);
    add9 = r_type(8, 8, 9, 6'h20);
    drive(add9, lw8, 32'h0, 1'b1);
    checks++;
    if ({de_halt, pc_en, fd_en} !== 3'b100) begin
      errors++; $display("FAIL load_use_stall: halt/pc/fd got %b want 100", {de_halt, pc_en, fd_en});
    end
    drive(add9, 32'h0, lw8, 1'b1);
    checks++;
    if ({de_halt, pc_en, fd_en} !== 3'b011) begin
      errors++; $display("FAIL load_use_after: halt/pc/fd got %b want 011", {de_halt, pc_en, fd_en});
    end
  endtask

  task automatic test_branch();
    drive(i_type(6'h04, 4, 0, 3), 32'h0, i_type(6'h23, 0, 4, 0), 1'b1);
    checks++;
    if (de_halt !== 1'b1) begin errors++; $display("FAIL beq_lw_m: got %b want 1", de_halt); end
    drive(i_type(6'h04, 0, 0, 3), i_type(6'h0d, 0, 0, 5), 32'h0, 1'b1);
    checks++;
    if (de_halt !== 1'b0) begin errors++; $display("FAIL beq_r0: got %b want 0", de_halt); end
  endtask

  task automatic run_mdu(input logic [5:0] fn, input int want, input string name);
    int busy_n, miss;
    logic [31:0] mflo2;
    busy_n = 0; miss = 0;
    mflo2 = r_type(0, 0, 2, 6'h12);
    drive(mflo2, r_type(1, 2, 0, fn), 32'h0, 1'b1);
    checks++;
    if ({de_halt, mdu_busy} !== 2'b10) begin
      errors++; $display("FAIL %s_in_e: halt/busy got %b want 10", name, {de_halt, mdu_busy});
    end
    for (int i = 0; i < 30; i++) begin
      drive(mflo2, 32'h0, 32'h0, 1'b1);
      if (mdu_busy !== 1'b1) break;
      busy_n++;
      if (de_halt !== 1'b1) miss++;
    end
    checks++;
    if (busy_n != want) begin
      errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, busy_n, want);
    end
    checks++;
    if (miss != 0) begin errors++; $display("FAIL %s_stall_gap: got %0d want 0", name, miss); end
    checks++;
    if (de_halt !== 1'b0) begin
      errors++; $display("FAIL %s_release: got %b want 0", name, de_halt);
    end
  endtask

  task automatic test_mdu();
    run_mdu(6'h18, MultCyc, "mult");
    run_mdu(6'h1a, DivCyc, "div");
  endtask

  task automatic test_reset_mid_count();
    drive(32'h0, r_type(3, 4, 0, 6'h1b), 32'h0, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (mdu_busy !== 1'b1) begin errors++; $display("FAIL mid_busy3: got %b want 1", mdu_busy); end
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (mdu_busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got %b want 0", mdu_busy); end
  endtask

  task automatic test_random();
    bit exp_stall;
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      drive(rand_instr(), rand_instr(), rand_instr(), ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      exp_stall = ref_stall(d_instr, e_instr, m_instr, model_cnt);
      checks++;
      if ({de_halt, pc_en, fd_en} !== {exp_stall, !exp_stall, !exp_stall}) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_stall: d=%h e=%h m=%h got %b want %b",
                               d_instr, e_instr, m_instr, {de_halt, pc_en, fd_en},
                               {exp_stall, !exp_stall, !exp_stall});
      end
      checks++;
      if (mdu_busy !== (model_cnt > 0)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_busy: got %b want %b", mdu_busy, model_cnt > 0);
      end
`ifdef HAZARD_STAT_EN
      checks++;
      if (stall_cnt !== model_stat) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_stat: got %0d want %0d", stall_cnt, model_stat);
      end
`endif
    end
  endtask

`ifdef HAZARD_STAT_EN
  task automatic test_stat();
    logic [31:0] lw8, add9, mflo2;
    lw8   = i_type(6'h23, 0, 8, 0);
    add9  = r_type(8, 8, 9, 6'h20);
    mflo2 = r_type(0, 0, 2, 6'h12);
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stat_clear: got %0d want 0", stall_cnt); end
    drive(add9, lw8, 32'h0, 1'b1);
    drive(add9, 32'h0, lw8, 1'b1);
    drive(mflo2, r_type(1, 2, 0, 6'h1a), 32'h0, 1'b1);
    for (int i = 0; i < DivCyc; i++) drive(mflo2, 32'h0, 32'h0, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (stall_cnt !== 32'd12) begin errors++; $display("FAIL stat_total: got %0d want 12", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_reset_mid_count();
    test_random();
`ifdef HAZARD_STAT_EN
    test_stat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
